// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: state, opcode and datapath-select encodings for the multicycle RISC-V controller
package riscv_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  function automatic logic op_legal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BR || op == OP_JAL;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus instruction fields to the ALU operation code
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_func3,
  input  logic [6:0] i_func7,
  input  logic [6:0] i_op,
  output logic [2:0] o_alu_control
);
  logic w_sub;
  // sub only for R-type with the sub/sra func7; I-type immediates may carry the same bit pattern
  assign w_sub = (i_op == OP_R) && (i_func7 == 7'b0100000);
  // ALUOp 00 adds, 01 subtracts, 10 decodes the function fields
  always_comb begin
    o_alu_control = ALU_ADD;
    if (i_alu_op == ALUOP_SUB) o_alu_control = ALU_SUB;
    else if (i_alu_op[1])
      case (i_func3)
        3'b000:  o_alu_control = w_sub ? ALU_SUB : ALU_ADD;
        3'b010:  o_alu_control = ALU_SLT;
        3'b110:  o_alu_control = ALU_OR;
        3'b111:  o_alu_control = ALU_AND;
        default: o_alu_control = ALU_ADD;
      endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the shared ALU/memory datapath of the multicycle core
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr,
  output logic [3:0] fsm_state
);
  state_t     r_state;
  state_t     w_next;
  state_t     w_st;
  logic [1:0] w_alu_op;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;
  // State register with synchronous active-low reset to FETCH
  always_ff @(posedge clk)
    if (!rst) r_state <= S_FETCH;
    else r_state <= w_next;
  // Next-state: memory states wait on mem_ready, DECODE and MEMADR branch on opcode
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = (Op == OP_LW || Op == OP_SW) ? S_MEMADR :
                           (Op == OP_R)   ? S_EXECUTER :
                           (Op == OP_I)   ? S_EXECUTEI :
                           (Op == OP_JAL) ? S_JAL :
                           (Op == OP_BR)  ? S_BRANCH : S_FETCH;
      S_MEMADR:   w_next = (Op == OP_LW) ? S_MEMREAD : (Op == OP_SW) ? S_MEMWRITE : S_FETCH;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end
  // While reset is held the selects decode as FETCH so the datapath sits in a known configuration
  assign w_st = rst ? r_state : S_FETCH;
  // Moore output decode; enables are raw here and gated by reset below
  always_comb begin
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    w_alu_op    = ALUOP_ADD;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    case (w_st)
      S_FETCH: begin
        ALUSrcB    = SRCB_4;
        ResultSrc  = RES_ALURES;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        w_illegal = !op_legal(Op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = SRCA_RS1;
        w_alu_op = ALUOP_FN;
      end
      S_EXECUTEI: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_IMM;
        w_alu_op = ALUOP_FN;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_4;
        w_pc_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        w_alu_op   = ALUOP_SUB;
        w_pc_write = Zero ^ func3[0];
      end
      default: ;
    endcase
  end
  assign PCWrite       = rst & w_pc_write;
  assign IRWrite       = rst & w_ir_write;
  assign MemWrite      = rst & w_mem_write;
  assign RegWrite      = rst & w_reg_write;
  assign illegal_instr = rst & w_illegal;
  assign fsm_state     = r_state;
  assign ImmSrc = (Op == OP_SW) ? IMM_S : (Op == OP_BR) ? IMM_B : (Op == OP_JAL) ? IMM_J : IMM_I;
  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_func3       (func3),
    .i_func7       (func7),
    .i_op          (Op),
    .o_alu_control (ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors checked through a scoreboard queue
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] Op = 7'b0000011;
  logic [2:0] func3 = 3'b000;
  logic [6:0] func7 = 7'b0000000;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] fsm_state;
  logic [20:0] q[$];
  int          tq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_step = 0;
  logic [6:0]  s_op = 7'b0000011;
  logic [2:0]  s_f3 = 3'b000;
  logic [6:0]  s_f7 = 7'b0000000;
  logic [1:0]  s_imm = 2'b00;
  logic [20:0] m_exp;
  logic [20:0] m_act;
  int          m_id;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .func3(func3), .func7(func7), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal_instr(illegal_instr), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB} expected in each state
  function automatic logic [6:0] state_sel(input logic [3:0] st);
    case (st)
      4'd0:    return 7'b0_10_00_10;
      4'd1:    return 7'b0_00_01_01;
      4'd2:    return 7'b0_00_10_01;
      4'd3:    return 7'b1_00_00_00;
      4'd4:    return 7'b0_01_00_00;
      4'd5:    return 7'b1_00_00_00;
      4'd6:    return 7'b0_00_10_00;
      4'd7:    return 7'b0_00_10_01;
      4'd9:    return 7'b0_00_01_10;
      4'd10:   return 7'b0_00_10_00;
      default: return 7'b0_00_00_00;
    endcase
  endfunction

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic [1:0] imm);
    s_op = op; s_f3 = f3; s_f7 = f7; s_imm = imm;
  endtask

  // One cycle: drive inputs after the edge and queue the outputs expected in that cycle
  // en = {PCWrite, IRWrite, MemWrite, RegWrite}
  task automatic step(input logic r, input logic mr, input logic z, input logic [3:0] st,
                      input logic [3:0] en, input logic ill, input logic [2:0] alu);
    @(posedge clk); #1;
    rst = r; mem_ready = mr; Zero = z; Op = s_op; func3 = s_f3; func7 = s_f7;
    q.push_back({st, en, ill, state_sel(r ? st : 4'd0), s_imm, alu});
    tq.push_back(n_step);
    n_step++;
  endtask

  // Monitor: compare the oldest expectation against the DUT mid-cycle
  always @(negedge clk)
    if (q.size() != 0) begin
      m_exp = q.pop_front();
      m_id  = tq.pop_front();
      m_act = {fsm_state, PCWrite, IRWrite, MemWrite, RegWrite, illegal_instr,
               AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
      n_checks++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL ctl_step%0d: got st=%0d en=%b ill=%b sel=%b imm=%b alu=%b, expected st=%0d en=%b ill=%b sel=%b imm=%b alu=%b",
                 m_id, m_act[20:17], m_act[16:13], m_act[12], m_act[11:5], m_act[4:3], m_act[2:0],
                 m_exp[20:17], m_exp[16:13], m_exp[12], m_exp[11:5], m_exp[4:3], m_exp[2:0]);
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    set_op(7'b0000011, 3'b010, 7'b0000000, 2'b00);
    repeat (3) step(0, 1, 0, 4'd0, 4'b0000, 0, 3'b000);
    // lw, no stalls: 5 cycles
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd2, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd3, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd4, 4'b0001, 0, 3'b000);
    // sw with three stall cycles in MEMWRITE
    set_op(7'b0100011, 3'b010, 7'b0000000, 2'b01);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd2, 4'b0000, 0, 3'b000);
    repeat (3) step(1, 0, 0, 4'd5, 4'b0010, 0, 3'b000);
    step(1, 1, 0, 4'd5, 4'b0010, 0, 3'b000);
    // R-type sub with one FETCH stall
    set_op(7'b0110011, 3'b000, 7'b0100000, 2'b00);
    step(1, 0, 0, 4'd0, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd6, 4'b0000, 0, 3'b001);
    step(1, 1, 0, 4'd8, 4'b0001, 0, 3'b000);
    // addi whose immediate mimics the sub func7: must still add
    set_op(7'b0010011, 3'b000, 7'b0100000, 2'b00);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd7, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd8, 4'b0001, 0, 3'b000);
    // R-type or, slt
    set_op(7'b0110011, 3'b110, 7'b0000000, 2'b00);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd6, 4'b0000, 0, 3'b011);
    step(1, 1, 0, 4'd8, 4'b0001, 0, 3'b000);
    set_op(7'b0110011, 3'b010, 7'b0000000, 2'b00);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd6, 4'b0000, 0, 3'b101);
    step(1, 1, 0, 4'd8, 4'b0001, 0, 3'b000);
    // andi
    set_op(7'b0010011, 3'b111, 7'b0000000, 2'b00);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd7, 4'b0000, 0, 3'b010);
    step(1, 1, 0, 4'd8, 4'b0001, 0, 3'b000);
    // jal
    set_op(7'b1101111, 3'b000, 7'b0000000, 2'b11);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd9, 4'b1000, 0, 3'b000);
    step(1, 1, 0, 4'd8, 4'b0001, 0, 3'b000);
    // beq taken, bne not taken, bne taken
    set_op(7'b1100011, 3'b000, 7'b0000000, 2'b10);
    step(1, 1, 1, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 1, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 1, 4'd10, 4'b1000, 0, 3'b001);
    set_op(7'b1100011, 3'b001, 7'b0000000, 2'b10);
    step(1, 1, 1, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 1, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 1, 4'd10, 4'b0000, 0, 3'b001);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd10, 4'b1000, 0, 3'b001);
    // unsupported opcode: one-cycle illegal pulse, back to FETCH
    set_op(7'b1111111, 3'b000, 7'b0000000, 2'b00);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 1, 3'b000);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    // lw abandoned by reset asserted during MEMWB
    set_op(7'b0000011, 3'b010, 7'b0000000, 2'b00);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd2, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd3, 4'b0000, 0, 3'b000);
    step(0, 1, 0, 4'd4, 4'b0000, 0, 3'b000);
    step(0, 1, 0, 4'd0, 4'b0000, 0, 3'b000);
    step(1, 1, 0, 4'd0, 4'b1100, 0, 3'b000);
    step(1, 1, 0, 4'd1, 4'b0000, 0, 3'b000);
    repeat (3) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
